even_div_ctrl: RTL and testbench
================================

// Module: even_div_ctrl
// PURPOSE
//  Run-time controller for even clock division. Produces a clean divided waveform (divisor = 2*half) plus
//  single-cycle rise/fall ticks in the clk domain. It takes ratio changes over a valid/ready handshake and
//  applies them only on a period boundary, so no runt pulse is ever generated. Sits beside the fixed
//  dividers and sequences start, stop and ratio changes for downstream clock-enable consumers.
// PARAMETERS
//  CNT_W     8   width of half-period count and ratio fields
//  DEF_HALF  5   half-period (in clk cycles) loaded at reset; 5 = divide-by-10
// PORTS
//  clk          in   1      single clock; all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  en           in   1      run enable (level)
//  cfg_valid    in   1      ratio change request
//  cfg_ready    out  1      controller can accept a request
//  cfg_half     in   CNT_W  requested half-period; divisor = 2*cfg_half
//  cur_half     out  CNT_W  half-period currently in effect
//  clk_div_o    out  1      divided waveform (registered)
//  tick_rise    out  1      1-cycle pulse; high in the first cycle clk_div_o reads 1
//  tick_fall    out  1      1-cycle pulse; high in the first cycle clk_div_o reads 0 after a high phase
//  cfg_err      out  1      1-cycle pulse; a request with cfg_half==0 was rejected
//  period_cnt   out  16     completed-rise count (only with EVEN_DIV_PERIOD_CNT_EN)
// BEHAVIOUR
//  Reset values: state=IDLE, cnt=0, clk_div_o=0, tick_rise=0, tick_fall=0, cfg_err=0, cfg_ready=1,
//  cur_half=DEF_HALF, pending cleared. Reset asserted mid-operation takes effect on the next edge.
//  Any pending ratio is discarded.
//  Handshake: a transfer occurs when cfg_valid && cfg_ready on a clock edge.
//  If cfg_half==0 at transfer, cfg_err=1 on the next cycle only. No other state changes.
//  States:
//   IDLE: clk_div_o=0, cnt=0. Accepted cfg loads cur_half on the next cycle.
//         When en=1: next cycle clk_div_o=1 and tick_rise=1, cnt=0, go to RUN.
//   RUN:  cnt increments each cycle. At cnt==cur_half-1: cnt<=0, clk_div_o toggles, and the matching
//         tick pulses. Result: high for cur_half cycles, low for cur_half cycles.
//         Accepted cfg goes to pend_half, state->PEND, cfg_ready=0 from the next cycle.
//   PEND: same counting as RUN. At the next 0->1 boundary, cur_half<=pend_half and the new high phase
//         already uses it. Return to RUN; cfg_ready=1 from the following cycle.
//  Stop: en sampled 0 in RUN or PEND completes the current period. At the point where the next rise would
//  occur, clk_div_o stays 0, no tick_rise, and the state goes to IDLE. A pending ratio is applied then.
//  Simultaneous events: if a cfg accept and a rising boundary happen in the same cycle, the new ratio
//  applies at the following boundary, not this one.
//  Boundary ratios: cur_half=1 toggles every cycle (div2). The maximum is 2^CNT_W-1.
//  cnt never exceeds cur_half-1, so it never wraps.
//  Latency: en 0->1 in IDLE gives the first rise 1 cycle later.
// CONFIGURATION
//  EVEN_DIV_PERIOD_CNT_EN defined: period_cnt increments on every tick_rise.
//   It wraps 16'hFFFF->0 and clears on rst.
//  Not defined: the period_cnt port and its logic are absent. Everything else is identical.
// STRUCTURE
//  Package even_div_pkg holds: the state enum (IDLE, RUN, PEND), the CNT_W default and DEF_HALF.
//  Sub-module even_div_phase_cnt contains the half-period counter and toggle flop:
//   inputs: half, run; outputs: boundary, level.
//  The top level holds the FSM, the handshake and the pending register.
// TESTING
//  1. rst, then en=1 with default 5 -> clk_div_o rises 1 cycle later, 5 high / 5 low; tick_rise every 10 clk.
//  2. IDLE, cfg_half=1, then en=1 -> clk_div_o toggles every cycle; tick_rise every 2 clk.
//  3. RUN half=5, cfg_half=3 during the high phase -> cfg_ready=0 until the next rise.
//     The current period stays 5/5, then 3/3; cur_half=3 from that rise.
//  4. cfg_half=0 with cfg_valid -> cfg_err=1 for exactly 1 cycle; cur_half unchanged; cfg_ready stays 1.
//  5. en dropped at cycle 2 of a high phase -> high 5, low 5, then clk_div_o held 0 and IDLE;
//     no further tick_rise.
//  6. rst pulsed while in PEND -> next cycle all outputs are at reset values, cur_half=DEF_HALF,
//     and the pending ratio never applies.

Source files
------------

// File: rtl/even_div_pkg.sv
// Shared types and defaults for the even clock-division controller.
// No logic; pure declarations.
package even_div_pkg;

    localparam int unsigned EVEN_DIV_CNT_W    = 8;
    localparam int unsigned EVEN_DIV_DEF_HALF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/even_div_phase_cnt.sv
// Half-period counter plus toggle flop; the level flips one cycle after boundary while run is high.
// No backpressure: run low forces cnt=0 and level=0 on the next edge.
module even_div_phase_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] half,
    input  logic             run,
    output logic             boundary,
    output logic             level
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             active_q;

    // While inactive every cycle is a boundary, so a start toggles the level immediately.
    assign boundary = !active_q || (cnt_q == (half - ONE));
    assign level    = level_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!run) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (boundary) begin
            cnt_d   = '0;
            level_d = !level_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            level_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            active_q <= run;
        end
    end

endmodule

// File: rtl/even_div_ctrl.sv
// Even clock-division controller: divided waveform, rise/fall ticks, ratio changes on period boundaries.
// First rise 1 cycle after en; cfg_ready drops while a ratio is pending. EVEN_DIV_PERIOD_CNT_EN adds period_cnt.
module even_div_ctrl
    import even_div_pkg::*;
#(
    parameter int unsigned CNT_W    = EVEN_DIV_CNT_W,
    parameter int unsigned DEF_HALF = EVEN_DIV_DEF_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [CNT_W-1:0] cur_half,
    output logic             clk_div_o,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             cfg_err
`ifdef EVEN_DIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);

    state_t           state_q;
    logic [CNT_W-1:0] cur_half_q;
    logic [CNT_W-1:0] pend_half_q;
    logic             cfg_ready_q;
    logic             cfg_err_q;
    logic             tick_rise_q;
    logic             tick_fall_q;
    logic             stop_q;

    logic             boundary;
    logic             level;
    logic             run;
    logic             rise_bnd;
    logic             fall_bnd;
    logic             stopping;
    logic             cfg_fire;
    logic             cfg_ok;

    assign cfg_fire = cfg_valid && cfg_ready_q;
    assign cfg_ok   = cfg_fire && (cfg_half != '0);
    assign rise_bnd = boundary && !level;
    assign fall_bnd = boundary && level;

    // A stop request only bites where the next rise would happen, so the last period completes.
    assign stopping = (state_q != IDLE) && rise_bnd && (stop_q || !en);
    assign run      = (state_q == IDLE) ? en : !stopping;

    even_div_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .half     (cur_half_q),
        .run      (run),
        .boundary (boundary),
        .level    (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_half_q  <= DEF_HALF_V;
            pend_half_q <= '0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            cfg_err_q   <= cfg_fire && (cfg_half == '0);
            tick_rise_q <= run && rise_bnd;
            tick_fall_q <= run && fall_bnd;
            case (state_q)
                IDLE: begin
                    stop_q <= 1'b0;
                    if (cfg_ok) begin
                        cur_half_q <= cfg_half;
                    end
                    if (en) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        stop_q <= 1'b1;
                    end
                    if (stopping) begin
                        state_q <= IDLE;
                        stop_q  <= 1'b0;
                        if (cfg_ok) begin
                            cur_half_q <= cfg_half;
                        end
                    end else if (cfg_ok) begin
                        // Even when this edge is a rise, the new ratio waits for the next one.
                        pend_half_q <= cfg_half;
                        state_q     <= PEND;
                        cfg_ready_q <= 1'b0;
                    end
                end
                PEND: begin
                    if (!en) begin
                        stop_q <= 1'b1;
                    end
                    if (rise_bnd) begin
                        cur_half_q  <= pend_half_q;
                        cfg_ready_q <= 1'b1;
                        if (stopping) begin
                            state_q <= IDLE;
                            stop_q  <= 1'b0;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cur_half  = cur_half_q;
    assign clk_div_o = level;
    assign tick_rise = tick_rise_q;
    assign tick_fall = tick_fall_q;
    assign cfg_err   = cfg_err_q;

`ifdef EVEN_DIV_PERIOD_CNT_EN
    logic [15:0] period_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_q <= '0;
        end else if (tick_rise_q) begin
            period_cnt_q <= period_cnt_q + 16'd1;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_even_div_ctrl.sv
// Directed bench for even_div_ctrl: per-cycle expected outputs queued as stimulus is applied,
// popped and compared half a clock after each rising edge.
module tb_even_div_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_half;
    logic [7:0] cur_half;
    logic       clk_div_o;
    logic       tick_rise;
    logic       tick_fall;
    logic       cfg_err;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic       div;
        logic       rise;
        logic       fall;
        logic       ready;
        logic       err;
        logic [7:0] half;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    even_div_ctrl #(
        .CNT_W    (8),
        .DEF_HALF (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
        .cur_half  (cur_half),
        .clk_div_o (clk_div_o),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .cfg_err   (cfg_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Inputs set before the call are sampled on the next rising edge; the expectation is the
    // output state right after that edge.
    task automatic cyc(input string tag, input logic e_div, input logic e_rise, input logic e_fall,
                       input logic e_ready, input logic e_err, input logic [7:0] e_half);
        exp_t e;
        exp_t got;
        e.div   = e_div;
        e.rise  = e_rise;
        e.fall  = e_fall;
        e.ready = e_ready;
        e.err   = e_err;
        e.half  = e_half;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = exp_q.pop_front();
        chk({tag, ".div"},   {7'd0, clk_div_o}, {7'd0, got.div});
        chk({tag, ".rise"},  {7'd0, tick_rise}, {7'd0, got.rise});
        chk({tag, ".fall"},  {7'd0, tick_fall}, {7'd0, got.fall});
        chk({tag, ".ready"}, {7'd0, cfg_ready}, {7'd0, got.ready});
        chk({tag, ".err"},   {7'd0, cfg_err},   {7'd0, got.err});
        chk({tag, ".half"},  cur_half,          got.half);
    endtask

    // Steady waveform j cycles after a rise for half-period h.
    task automatic wave(input string tag, input int h, input int j, input logic e_ready,
                        input logic e_err, input logic [7:0] e_half);
        int m;
        m = j % (2 * h);
        cyc(tag, (m < h), (m == 0), (m == h), e_ready, e_err, e_half);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;

        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        rst = 1'b0;
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);

        // Default div-by-10, then en dropped in the second cycle of a high phase.
        en = 1'b1;
        for (int j = 0; j < 30; j++) begin
            if (j == 22) en = 1'b0;
            wave("div10", 5, j, 1'b1, 1'b0, 8'd5);
        end
        for (int j = 0; j < 4; j++) cyc("stop10", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);

        // Div-by-2 loaded while idle.
        cfg_valid = 1'b1;
        cfg_half  = 8'd1;
        cyc("cfg1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        cfg_valid = 1'b0;
        en        = 1'b1;
        for (int j = 0; j < 8; j++) wave("div2", 1, j, 1'b1, 1'b0, 8'd1);
        en = 1'b0;
        for (int j = 0; j < 3; j++) cyc("stop2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        cfg_valid = 1'b1;
        cfg_half  = 8'd5;
        cyc("cfg5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        cfg_valid = 1'b0;

        // Ratio change during a high phase applies at the next rise.
        en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j == 2) begin
                cfg_valid = 1'b1;
                cfg_half  = 8'd3;
            end
            if (j == 3) cfg_valid = 1'b0;
            wave("chg53", 5, j, (j < 2), 1'b0, 8'd5);
        end
        // Zero request rejected, then a pending ratio that reset must discard.
        for (int k = 0; k < 9; k++) begin
            if (k == 4) begin
                cfg_valid = 1'b1;
                cfg_half  = 8'd0;
            end
            if (k == 5) cfg_valid = 1'b0;
            if (k == 7) begin
                cfg_valid = 1'b1;
                cfg_half  = 8'd7;
            end
            if (k == 8) cfg_valid = 1'b0;
            wave("div6", 3, k, (k < 7), (k == 4), 8'd3);
        end
        rst = 1'b1;
        en  = 1'b0;
        cyc("rst_pend", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        rst = 1'b0;
        cyc("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);

        // Request accepted on a rising edge waits one full period.
        en = 1'b1;
        for (int j = 0; j < 30; j++) begin
            if (j == 10) begin
                cfg_valid = 1'b1;
                cfg_half  = 8'd2;
            end
            if (j == 11) cfg_valid = 1'b0;
            if (j < 20) wave("simul", 5, j, (j < 10), 1'b0, 8'd5);
            else        wave("div4", 2, j - 20, 1'b1, 1'b0, 8'd2);
        end
        en = 1'b0;
        for (int k = 10; k < 12; k++) wave("stop4", 2, k, 1'b1, 1'b0, 8'd2);
        cyc("idle4", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);

        // Largest ratio, stop requested during the low phase.
        cfg_valid = 1'b1;
        cfg_half  = 8'd255;
        cyc("cfg255", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
        cfg_valid = 1'b0;
        en        = 1'b1;
        for (int j = 0; j < 510; j++) begin
            if (j == 300) en = 1'b0;
            wave("div510", 255, j, 1'b1, 1'b0, 8'd255);
        end
        for (int j = 0; j < 3; j++) cyc("stop510", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
